em_feeder: RTL and testbench
============================

EM_FEEDER -- requirements
Module: em_feeder

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 256: weight rows streamed per job.
REQ-002 SHALL have parameter ROW_W, default 256: bits per weight row and per spin vector.
REQ-003 SHALL have parameter CFG_W, default 32: config word width.
REQ-004 SHALL have parameter ENERGY_W, default 32: energy result width.
REQ-005 SHALL have port clk_i  in  1: single clock, rising edge.
REQ-006 SHALL have port rst_i  in  1: reset, synchronous and active-high.
REQ-007 SHALL have port en_i  in  1: block enable; low aborts any job.
REQ-008 SHALL have ports start_i  in  1, cfg_i  in  CFG_W, spin_i  in  ROW_W: job start; cfg_i and spin_i are sampled on the start cycle.
REQ-009 SHALL have ports busy_o  out  1: job in progress; done_o  out  1: one-cycle completion pulse.
REQ-010 SHALL have ports config_valid_o  out  1, config_ready_i  in  1, config_o  out  CFG_W: config channel to the monitor.
REQ-011 SHALL have ports spin_valid_o  out  1, spin_ready_i  in  1, spin_o  out  ROW_W: spin channel.
REQ-012 SHALL have ports weight_valid_o  out  1, weight_ready_i  in  1, weight_o  out  ROW_W: weight row stream.
REQ-013 SHALL have ports mem_req_o  out  1, mem_addr_o  out  $clog2(NUM_ROWS), mem_rdata_i  in  ROW_W: weight memory read port, data valid exactly 1 cycle after req.
REQ-014 SHALL have ports energy_valid_i  in  1, energy_ready_o  out  1, energy_i  in  ENERGY_W, energy_o  out  ENERGY_W: result channel and latched result.

Function
REQ-015 SHALL implement FSM IDLE -> CFG -> SPIN -> STREAM -> WAIT_E -> IDLE.
REQ-016 IDLE: start_i && en_i SHALL latch cfg_i/spin_i and enter CFG next cycle; busy_o = (state != IDLE).
REQ-017 CFG: config_valid_o SHALL be high; on config_valid_o && config_ready_i, enter SPIN.
REQ-018 SPIN: spin_valid_o SHALL be high; on handshake, enter STREAM and clear row counters.
REQ-019 config_o/spin_o SHALL hold the latched values stable while valid is high.
REQ-020 STREAM: mem_addr_o SHALL issue rows 0..NUM_ROWS-1 in order, one req per cycle max.
REQ-021 Read data SHALL enter a 2-entry FIFO; a req SHALL issue only if entries + in-flight < 2.
REQ-022 weight_valid_o = FIFO not empty; weight_o = FIFO head; both stable while stalled.
REQ-023 Sustained weight_ready_i high SHALL yield one row per cycle after a 2-cycle initial latency from STREAM entry.
REQ-024 After the NUM_ROWS-th weight handshake, SHALL enter WAIT_E; no further mem_req_o.
REQ-025 WAIT_E: energy_ready_o SHALL be high; on energy handshake, latch energy_i into energy_o, pulse done_o for one cycle, return to IDLE.
REQ-026 energy_ready_o SHALL be low in all other states; an early energy_valid_i is left pending.
REQ-027 start_i while busy_o SHALL be ignored.
REQ-028 en_i low in any state SHALL force IDLE next cycle, flush FIFO, discard in-flight read, drop all valids, no done_o; energy_o kept.
REQ-029 start_i and en_i low in the same cycle SHALL be ignored.

Reset
REQ-030 rst_i SHALL force IDLE; all valids, mem_req_o, energy_ready_o, busy_o, done_o = 0; counters, FIFO, energy_o = 0.
REQ-031 rst_i mid-job SHALL abort identically; rst_i dominates en_i and start_i.

Structure
REQ-032 Package em_pkg SHALL hold the FSM state enum and default parameter constants, shared with the monitor.
REQ-033 FIFO SHALL be sub-module em_skid_fifo (depth 2, width ROW_W, push/pop/flush, full/empty).

Verification
REQ-034 NUM_ROWS=4, all readies high, start cfg=0xA5, spin=0x1 -> config then spin handshakes on consecutive cycles, 4 weight beats rows 0..3 back to back, energy 0x1234 -> energy_o=0x1234, done_o one pulse.
REQ-035 weight_ready_i toggling 1/0 -> rows in order, none duplicated/dropped, weight_o stable while stalled, FIFO never overflows.
REQ-036 config_ready_i low 5 cycles -> config_valid_o held 5 cycles, config_o unchanged, spin not offered.
REQ-037 en_i low after row 2 -> IDLE next cycle, valids 0, no done_o; new start streams from row 0.
REQ-038 energy_valid_i asserted during STREAM -> energy_ready_o low until WAIT_E, then latched in first WAIT_E cycle.
REQ-039 rst_i during WAIT_E, start_i pulse while busy -> reset values per REQ-030; ignored start causes no restart.

Source files
------------

// File: rtl/em_pkg.sv
// Shared constants and FSM encoding for the energy-monitor feeder and its monitor.
package em_pkg;

    localparam int unsigned EM_NUM_ROWS = 256;
    localparam int unsigned EM_ROW_W    = 256;
    localparam int unsigned EM_CFG_W    = 32;
    localparam int unsigned EM_ENERGY_W = 32;

    typedef logic [2:0] em_state_t;

    localparam em_state_t StIdle   = 3'd0;
    localparam em_state_t StCfg    = 3'd1;
    localparam em_state_t StSpin   = 3'd2;
    localparam em_state_t StStream = 3'd3;
    localparam em_state_t StWaitE  = 3'd4;

endpackage

// File: rtl/em_skid_fifo.sv
// Two-entry FIFO that buffers weight rows between the memory read port and the stream.
module em_skid_fifo #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/em_feeder.sv
// Feeds one job (config word, spin vector, NUM_ROWS weight rows) to the energy monitor
// and latches the energy it returns.
module em_feeder
    import em_pkg::*;
#(
    parameter int unsigned NUM_ROWS = EM_NUM_ROWS,
    parameter int unsigned ROW_W    = EM_ROW_W,
    parameter int unsigned CFG_W    = EM_CFG_W,
    parameter int unsigned ENERGY_W = EM_ENERGY_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        start_i,
    input  logic [CFG_W-1:0]            cfg_i,
    input  logic [ROW_W-1:0]            spin_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        config_valid_o,
    input  logic                        config_ready_i,
    output logic [CFG_W-1:0]            config_o,
    output logic                        spin_valid_o,
    input  logic                        spin_ready_i,
    output logic [ROW_W-1:0]            spin_o,
    output logic                        weight_valid_o,
    input  logic                        weight_ready_i,
    output logic [ROW_W-1:0]            weight_o,
    output logic                        mem_req_o,
    output logic [$clog2(NUM_ROWS)-1:0] mem_addr_o,
    input  logic [ROW_W-1:0]            mem_rdata_i,
    input  logic                        energy_valid_i,
    output logic                        energy_ready_o,
    input  logic [ENERGY_W-1:0]         energy_i,
    output logic [ENERGY_W-1:0]         energy_o
);

    localparam int unsigned ADDR_W = $clog2(NUM_ROWS);
    localparam int unsigned CNT_W  = $clog2(NUM_ROWS + 1);
    localparam logic [CNT_W-1:0] ROWS     = CNT_W'(NUM_ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

    em_state_t            state_q, state_d;
    logic [CFG_W-1:0]     cfg_q;
    logic [ROW_W-1:0]     spin_q;
    logic [ENERGY_W-1:0]  energy_q;
    logic [CNT_W-1:0]     req_cnt_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic                 inflight_q;
    logic                 done_q;

    logic                 in_stream;
    logic                 spin_fire;
    logic                 energy_fire;
    logic                 last_beat;
    logic                 credit;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [1:0]           fifo_count;
    logic [ROW_W-1:0]     fifo_data;

    // Outputs are gated by en_i so nothing can handshake in the cycle a job is aborted.
    assign in_stream      = en_i && (state_q == StStream);
    assign config_valid_o = en_i && (state_q == StCfg);
    assign spin_valid_o   = en_i && (state_q == StSpin);
    assign energy_ready_o = en_i && (state_q == StWaitE);
    assign weight_valid_o = in_stream && !fifo_empty;
    assign config_o       = cfg_q;
    assign spin_o         = spin_q;
    assign weight_o       = fifo_data;
    assign energy_o       = energy_q;
    assign busy_o         = (state_q != StIdle);
    assign done_o         = done_q;

    assign spin_fire   = spin_valid_o && spin_ready_i;
    assign energy_fire = energy_ready_o && energy_valid_i;
    assign fifo_pop    = weight_valid_o && weight_ready_i;
    assign fifo_push   = in_stream && inflight_q;
    assign last_beat   = fifo_pop && (beat_cnt_q == LAST_ROW);

    // FIFO entries plus the read in flight must stay below two; a same-cycle pop frees a slot.
    always_comb begin
        credit = 1'b0;
        if (fifo_full) begin
            credit = fifo_pop && !inflight_q;
        end else begin
            credit = (fifo_count == 2'd0) || !inflight_q || fifo_pop;
        end
    end

    assign mem_req_o  = in_stream && (req_cnt_q < ROWS) && credit;
    assign mem_addr_o = req_cnt_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_i)        state_d = StCfg;
            StCfg:    if (config_ready_i) state_d = StSpin;
            StSpin:   if (spin_ready_i)   state_d = StStream;
            StStream: if (last_beat)      state_d = StWaitE;
            StWaitE:  if (energy_valid_i) state_d = StIdle;
            default:                      state_d = StIdle;
        endcase
        if (!en_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cfg_q      <= '0;
            spin_q     <= '0;
            energy_q   <= '0;
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= energy_fire;
            inflight_q <= mem_req_o;
            if ((state_q == StIdle) && start_i && en_i) begin
                cfg_q  <= cfg_i;
                spin_q <= spin_i;
            end
            if (!en_i || spin_fire) begin
                req_cnt_q  <= '0;
                beat_cnt_q <= '0;
            end else begin
                if (mem_req_o) req_cnt_q  <= req_cnt_q + 1'b1;
                if (fifo_pop)  beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (energy_fire) begin
                energy_q <= energy_i;
            end
        end
    end

    em_skid_fifo #(
        .WIDTH (ROW_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (!en_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (mem_rdata_i),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_em_feeder.sv
// Scoreboard bench for em_feeder: stimulus queues expected beats, a negedge monitor checks them.
module tb_em_feeder;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] cfg_i = '0;
    logic [31:0] spin_i = '0;
    logic        busy_o, done_o;
    logic        config_valid_o, spin_valid_o, weight_valid_o;
    logic        config_ready_i = 1'b1;
    logic        spin_ready_i = 1'b1;
    logic        weight_ready_i = 1'b1;
    logic [31:0] config_o, spin_o, weight_o;
    logic        mem_req_o;
    logic [1:0]  mem_addr_o;
    logic [31:0] mem_rdata_i = '0;
    logic        energy_valid_i = 1'b0;
    logic        energy_ready_o;
    logic [31:0] energy_i = '0;
    logic [31:0] energy_o;

    em_feeder #(
        .NUM_ROWS (NR),
        .ROW_W    (32),
        .CFG_W    (32),
        .ENERGY_W (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .start_i        (start_i),
        .cfg_i          (cfg_i),
        .spin_i         (spin_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .config_valid_o (config_valid_o),
        .config_ready_i (config_ready_i),
        .config_o       (config_o),
        .spin_valid_o   (spin_valid_o),
        .spin_ready_i   (spin_ready_i),
        .spin_o         (spin_o),
        .weight_valid_o (weight_valid_o),
        .weight_ready_i (weight_ready_i),
        .weight_o       (weight_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .energy_valid_i (energy_valid_i),
        .energy_ready_o (energy_ready_o),
        .energy_i       (energy_i),
        .energy_o       (energy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] exp_cfg[$];
    logic [31:0] exp_spin[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_e[$];

    int exp_addr = 0, job_beats = 0, outstanding = 0, done_cnt = 0;
    int cfg_fire_cyc = 0, spin_fire_cyc = 0, first_w_cyc = 0, last_w_cyc = 0, e_fire_cyc = 0;
    bit w_stall = 0, c_stall = 0, done_prev = 0;
    logic [31:0] w_held = '0, c_held = '0;

    function automatic logic [31:0] row_data(int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(string name, string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s expected none", name, what);
    endtask

    // Weight memory: data valid exactly one cycle after the request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req_o) mem_rdata_i <= row_data(int'(mem_addr_o));
    end

    always @(negedge clk) begin
        if (rst_i) begin
            exp_addr = 0; job_beats = 0; outstanding = 0;
            w_stall = 0; c_stall = 0; done_prev = 0;
        end else begin
            if (!busy_o) begin
                exp_addr = 0; job_beats = 0; outstanding = 0; w_stall = 0; c_stall = 0;
            end
            if (w_stall && en_i) begin
                chk("w_hold_valid", weight_valid_o, 1);
                chk("w_hold_data", weight_o, w_held);
            end
            if (c_stall && en_i) begin
                chk("c_hold_valid", config_valid_o, 1);
                chk("c_hold_data", config_o, c_held);
            end
            w_stall = weight_valid_o && !weight_ready_i;
            w_held  = weight_o;
            c_stall = config_valid_o && !config_ready_i;
            c_held  = config_o;
            if (config_valid_o && config_ready_i) begin
                cfg_fire_cyc = cyc;
                if (exp_cfg.size() == 0) note_fail("config_unexpected", "beat");
                else chk("config", config_o, exp_cfg.pop_front());
            end
            if (spin_valid_o && spin_ready_i) begin
                spin_fire_cyc = cyc;
                if (exp_spin.size() == 0) note_fail("spin_unexpected", "beat");
                else chk("spin", spin_o, exp_spin.pop_front());
            end
            if (weight_valid_o && weight_ready_i) begin
                job_beats++;
                outstanding--;
                if (job_beats == 1) first_w_cyc = cyc;
                last_w_cyc = cyc;
                if (exp_w.size() == 0) note_fail("weight_unexpected", "beat");
                else chk("weight", weight_o, exp_w.pop_front());
            end
            if (mem_req_o) begin
                chk("mem_addr", mem_addr_o, exp_addr);
                exp_addr++;
                outstanding++;
                chk("outstanding_le2", outstanding <= 2, 1);
            end
            if (energy_ready_o) chk("eready_only_wait", job_beats, NR);
            if (energy_ready_o && energy_valid_i) e_fire_cyc = cyc;
            if (done_o) begin
                done_cnt++;
                chk("done_single", done_prev, 0);
                if (exp_e.size() == 0) note_fail("done_unexpected", "pulse");
                else chk("energy_o", energy_o, exp_e.pop_front());
            end
            done_prev = done_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(logic [31:0] c, logic [31:0] s);
        cfg_i = c;
        spin_i = s;
        start_i = 1'b1;
        exp_cfg.push_back(c);
        exp_spin.push_back(s);
        for (int i = 0; i < NR; i++) exp_w.push_back(row_data(i));
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_to_idle(string name, bit toggle, int limit);
        int n = 0;
        while (busy_o && n < limit) begin
            tick();
            n++;
            if (toggle) weight_ready_i = ~weight_ready_i;
        end
        if (busy_o) note_fail(name, "timeout");
        tick();
    endtask

    task automatic wait_beats(string name, int b, int limit);
        int n = 0;
        while (job_beats < b && n < limit) begin
            tick();
            n++;
        end
        if (job_beats < b) note_fail(name, "timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        // Reset values
        tick();
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_cfg_valid", config_valid_o, 0);
        chk("rst_spin_valid", spin_valid_o, 0);
        chk("rst_w_valid", weight_valid_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_eready", energy_ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_energy", energy_o, 0);
        rst_i = 1'b0;
        tick();

        // Basic job, early energy_valid held through STREAM
        energy_i = 32'h1234;
        energy_valid_i = 1'b1;
        exp_e.push_back(32'h1234);
        start_job(32'hA5, 32'h1);
        run_to_idle("job1_idle", 0, 50);
        chk("spin_after_cfg", spin_fire_cyc, cfg_fire_cyc + 1);
        chk("first_w_latency", first_w_cyc, spin_fire_cyc + 3);
        chk("w_back_to_back", last_w_cyc, first_w_cyc + NR - 1);
        chk("energy_first_wait", e_fire_cyc, last_w_cyc + 1);
        chk("job1_done_cnt", done_cnt, 1);
        energy_valid_i = 1'b0;

        // Toggling weight_ready
        energy_i = 32'h5555;
        energy_valid_i = 1'b1;
        exp_e.push_back(32'h5555);
        start_job(32'h5A, 32'hF0);
        run_to_idle("toggle_idle", 1, 80);
        weight_ready_i = 1'b1;
        energy_valid_i = 1'b0;
        chk("toggle_done_cnt", done_cnt, 2);

        // Config back-pressure for 5 cycles
        config_ready_i = 1'b0;
        energy_i = 32'h77;
        energy_valid_i = 1'b1;
        exp_e.push_back(32'h77);
        start_job(32'h3C, 32'h2);
        for (int i = 0; i < 5; i++) begin
            chk("cstall_valid", config_valid_o, 1);
            chk("cstall_data", config_o, 32'h3C);
            chk("cstall_no_spin", spin_valid_o, 0);
            tick();
        end
        config_ready_i = 1'b1;
        run_to_idle("cstall_idle", 0, 50);
        energy_valid_i = 1'b0;

        // Abort via en_i after row 2, then restart from row 0
        d0 = done_cnt;
        start_job(32'h11, 32'h3);
        wait_beats("abort_wait", 3, 50);
        en_i = 1'b0;
        tick();
        chk("abort_busy", busy_o, 0);
        chk("abort_w_valid", weight_valid_o, 0);
        chk("abort_mem_req", mem_req_o, 0);
        chk("abort_energy_kept", energy_o, 32'h77);
        en_i = 1'b1;
        exp_w.delete();
        tick();
        tick();
        chk("abort_no_done", done_cnt, d0);
        energy_i = 32'h99;
        energy_valid_i = 1'b1;
        exp_e.push_back(32'h99);
        start_job(32'h22, 32'h4);
        run_to_idle("restart_idle", 0, 50);
        energy_valid_i = 1'b0;
        chk("restart_energy", energy_o, 32'h99);

        // start_i with en_i low is ignored
        en_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        en_i = 1'b1;
        chk("start_en_low", busy_o, 0);

        // Ignored start while busy, then reset in WAIT_E dominating start
        start_job(32'h44, 32'h5);
        wait_beats("busy_start_wait", 2, 50);
        cfg_i = 32'hEE;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        begin
            int n = 0;
            while (!energy_ready_o && n < 50) begin
                tick();
                n++;
            end
            if (!energy_ready_o) note_fail("wait_e_reach", "timeout");
        end
        rst_i = 1'b1;
        start_i = 1'b1;
        tick();
        rst_i = 1'b0;
        start_i = 1'b0;
        chk("rst2_busy", busy_o, 0);
        chk("rst2_eready", energy_ready_o, 0);
        chk("rst2_cfg_valid", config_valid_o, 0);
        chk("rst2_w_valid", weight_valid_o, 0);
        chk("rst2_mem_req", mem_req_o, 0);
        chk("rst2_done", done_o, 0);
        chk("rst2_energy", energy_o, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("no_restart_busy", busy_o, 0);
        chk("no_restart_cfg", config_valid_o, 0);

        chk("q_cfg_empty", exp_cfg.size(), 0);
        chk("q_spin_empty", exp_spin.size(), 0);
        chk("q_w_empty", exp_w.size(), 0);
        chk("q_e_empty", exp_e.size(), 0);
        chk("total_done", done_cnt, d0 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
